alu: RTL and testbench

Single-cycle-latency 8-bit arithmetic/logic unit for the GameBuddy SM83 (Game Boy) CPU datapath. Computes the eight accumulator ALU operations, or, with `ext` set, the eight CB-prefix rotate/shift/swap operations. Produces the 8-bit result and the Z/N/H/C flag byte together in one registered 16-bit word. Sits between the register file / operand muxes and the A and F register write-back.

---
 rtl/alu.sv | 99 +++++++++
 tb/tb_alu.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: registered 8-bit SM83 ALU; accumulator group or CB rotate/shift group,
// producing {result, Z N H C 0000} one cycle after the operands are sampled.
`default_nettype none

module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  op,
  input  logic [7:0]  src_data,
  input  logic [7:0]  dest_data,
  input  logic        ext,
  input  logic        misc,
  output logic [15:0] res
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  logic        carry_in;
  logic        borrow_in;
  logic [8:0]  add_full;
  logic [4:0]  add_nib;
  logic [8:0]  sub_full;
  logic [4:0]  sub_nib;
  logic [7:0]  calc;
  logic [7:0]  out_byte;
  logic        flag_n;
  logic        flag_h;
  logic        flag_c;
  logic [15:0] res_d;
  logic [15:0] res_q;

  assign carry_in  = (op == OP_ADC) ? misc : 1'b0;
  assign borrow_in = (op == OP_SBC) ? misc : 1'b0;

  // 9/5-bit differences: the top bit is the borrow, since the true difference
  // never falls below -256 (or -16 for the nibble).
  assign add_full = {1'b0, dest_data} + {1'b0, src_data} + {8'd0, carry_in};
  assign add_nib  = {1'b0, dest_data[3:0]} + {1'b0, src_data[3:0]} + {4'd0, carry_in};
  assign sub_full = {1'b0, dest_data} - {1'b0, src_data} - {8'd0, borrow_in};
  assign sub_nib  = {1'b0, dest_data[3:0]} - {1'b0, src_data[3:0]} - {4'd0, borrow_in};

  always_comb begin
    calc   = 8'd0;
    flag_n = 1'b0;
    flag_h = 1'b0;
    flag_c = 1'b0;
    if (ext) begin
      case (op)
        3'd0: begin calc = {dest_data[6:0], dest_data[7]};    flag_c = dest_data[7]; end
        3'd1: begin calc = {dest_data[0], dest_data[7:1]};    flag_c = dest_data[0]; end
        3'd2: begin calc = {dest_data[6:0], misc};            flag_c = dest_data[7]; end
        3'd3: begin calc = {misc, dest_data[7:1]};            flag_c = dest_data[0]; end
        3'd4: begin calc = {dest_data[6:0], 1'b0};            flag_c = dest_data[7]; end
        3'd5: begin calc = {dest_data[7], dest_data[7:1]};    flag_c = dest_data[0]; end
        3'd6: begin calc = {dest_data[3:0], dest_data[7:4]};  flag_c = 1'b0;         end
        default: begin calc = {1'b0, dest_data[7:1]};         flag_c = dest_data[0]; end
      endcase
    end else begin
      case (op)
        OP_ADD, OP_ADC: begin
          calc   = add_full[7:0];
          flag_h = add_nib[4];
          flag_c = add_full[8];
        end
        OP_SUB, OP_SBC, OP_CP: begin
          calc   = sub_full[7:0];
          flag_n = 1'b1;
          flag_h = sub_nib[4];
          flag_c = sub_full[8];
        end
        OP_AND: begin calc = dest_data & src_data; flag_h = 1'b1; end
        OP_XOR: calc = dest_data ^ src_data;
        OP_OR:  calc = dest_data | src_data;
        default: calc = 8'd0;
      endcase
    end
  end

  // CP leaves A untouched but its Z flag still comes from the difference.
  assign out_byte = (!ext && op == OP_CP) ? dest_data : calc;
  assign res_d    = {out_byte, (calc == 8'd0), flag_n, flag_h, flag_c, 4'b0000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= 16'h0000;
    else        res_q <= res_d;
  end

  assign res = res_q;

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// tb_alu: directed vector table, reset/hold corner cases, and an exhaustive
// small-operand sweep plus random ops checked against an arithmetic model.
`default_nettype none

module tb_alu;
  logic        clk;
  logic        rst_n;
  logic [2:0]  op;
  logic [7:0]  src_data;
  logic [7:0]  dest_data;
  logic        ext;
  logic        misc;
  logic [15:0] res;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk(clk), .rst_n(rst_n), .op(op), .src_data(src_data),
    .dest_data(dest_data), .ext(ext), .misc(misc), .res(res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ext;
    logic [2:0]  op;
    logic [7:0]  d;
    logic [7:0]  s;
    logic        m;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] model(input int o, input int e, input int d,
                                        input int s, input int m);
    int r, outv, fn, fh, fc;
    r = 0; fn = 0; fh = 0; fc = 0;
    if (e != 0) begin
      case (o)
        0: begin r = d * 2 + d / 128;             fc = d / 128; end
        1: begin r = d / 2 + (d % 2) * 128;       fc = d % 2;   end
        2: begin r = d * 2 + m;                   fc = d / 128; end
        3: begin r = d / 2 + m * 128;             fc = d % 2;   end
        4: begin r = d * 2;                       fc = d / 128; end
        5: begin r = d / 2 + (d / 128) * 128;     fc = d % 2;   end
        6: begin r = (d % 16) * 16 + d / 16;      fc = 0;       end
        default: begin r = d / 2;                 fc = d % 2;   end
      endcase
    end else begin
      case (o)
        0, 1: begin
          int ci;
          ci = (o == 1) ? m : 0;
          r  = d + s + ci;
          fh = ((d % 16) + (s % 16) + ci > 15) ? 1 : 0;
          fc = (r > 255) ? 1 : 0;
        end
        2, 3, 7: begin
          int bi;
          bi = (o == 3) ? m : 0;
          r  = d - s - bi + 256;
          fn = 1;
          fh = ((d % 16) < (s % 16) + bi) ? 1 : 0;
          fc = (d < s + bi) ? 1 : 0;
        end
        4: begin r = d & s; fh = 1; end
        5: r = d ^ s;
        default: r = d | s;
      endcase
    end
    r    = r % 256;
    outv = (e == 0 && o == 7) ? d : r;
    return 16'(outv * 256 + ((r == 0) ? 128 : 0) + fn * 64 + fh * 32 + fc * 16);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [2:0] o, input logic [7:0] d,
                       input logic [7:0] s, input logic m);
    ext = e; op = o; dest_data = d; src_data = s; misc = m;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 8'h0F, 8'h01, 1'b0);
    repeat (2) @(posedge clk);
    #1 check("reset_state", res, 16'h0000);

    vecs.push_back('{"ADD_H",   1'b0, 3'd0, 8'h0F, 8'h01, 1'b0, 16'h1020});
    vecs.push_back('{"ADC_ZHC", 1'b0, 3'd1, 8'hFF, 8'h00, 1'b1, 16'h00B0});
    vecs.push_back('{"SUB_ZN",  1'b0, 3'd2, 8'h05, 8'h05, 1'b0, 16'h00C0});
    // 0x10-0x0F-1 is zero, so Z accompanies N and H.
    vecs.push_back('{"SBC_ZNH", 1'b0, 3'd3, 8'h10, 8'h0F, 1'b1, 16'h00E0});
    vecs.push_back('{"CP_NHC",  1'b0, 3'd7, 8'h03, 8'h04, 1'b0, 16'h0370});
    vecs.push_back('{"AND_ZH",  1'b0, 3'd4, 8'hF0, 8'h0F, 1'b0, 16'h00A0});
    vecs.push_back('{"XOR",     1'b0, 3'd5, 8'hA5, 8'h0F, 1'b1, 16'hAA00});
    vecs.push_back('{"OR",      1'b0, 3'd6, 8'h00, 8'h00, 1'b1, 16'h0080});
    vecs.push_back('{"RLC",     1'b1, 3'd0, 8'h80, 8'h55, 1'b0, 16'h0110});
    vecs.push_back('{"RRC",     1'b1, 3'd1, 8'h01, 8'h00, 1'b0, 16'h8010});
    vecs.push_back('{"RL",      1'b1, 3'd2, 8'h40, 8'h00, 1'b1, 16'h8100});
    vecs.push_back('{"RR_ZC",   1'b1, 3'd3, 8'h01, 8'hFF, 1'b0, 16'h0090});
    vecs.push_back('{"SLA",     1'b1, 3'd4, 8'hC1, 8'h00, 1'b1, 16'h8210});
    vecs.push_back('{"SRA",     1'b1, 3'd5, 8'h81, 8'h00, 1'b0, 16'hC010});
    vecs.push_back('{"SWAP",    1'b1, 3'd6, 8'hF0, 8'h00, 1'b1, 16'h0F00});
    vecs.push_back('{"SRL",     1'b1, 3'd7, 8'h81, 8'h00, 1'b1, 16'h4010});

    // First edge after release captures the inputs already present.
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("first_edge_after_reset", res, 16'h1020);

    foreach (vecs[i]) begin
      drive(vecs[i].ext, vecs[i].op, vecs[i].d, vecs[i].s, vecs[i].m);
      @(posedge clk);
      #1 check(vecs[i].name, res, vecs[i].exp);
    end

    // Mid-cycle input change must not disturb the registered result.
    drive(1'b0, 3'd0, 8'h0F, 8'h01, 1'b0);
    @(posedge clk);
    #2 drive(1'b0, 3'd2, 8'h05, 8'h05, 1'b0);
    #2 check("hold_between_edges", res, 16'h1020);
    @(posedge clk);
    #1 check("next_edge_update", res, 16'h00C0);

    // Asynchronous reset while res is nonzero.
    drive(1'b1, 3'd0, 8'h80, 8'h00, 1'b0);
    @(posedge clk);
    #1 check("pre_reset_value", res, 16'h0110);
    #2 rst_n = 1'b0;
    #1 check("async_reset_immediate", res, 16'h0000);
    @(posedge clk);
    #1 check("reset_held_across_edge", res, 16'h0000);
    rst_n = 1'b1;
    #2 check("reset_released_no_edge", res, 16'h0000);
    @(posedge clk);
    #1 check("capture_after_release", res, 16'h0110);

    for (int e = 0; e < 2; e++)
      for (int o = 0; o < 8; o++)
        for (int d = 0; d <= 16; d++)
          for (int s = 0; s <= 16; s++)
            for (int m = 0; m < 2; m++) begin
              drive(e[0], o[2:0], d[7:0], s[7:0], m[0]);
              @(posedge clk);
              #1 check("sweep", res, model(o, e, d, s, m));
            end

    for (int k = 0; k < 3000; k++) begin
      int e, o, d, s, m;
      e = $urandom_range(1, 0); o = $urandom_range(7, 0);
      d = $urandom_range(255, 0); s = $urandom_range(255, 0); m = $urandom_range(1, 0);
      drive(e[0], o[2:0], d[7:0], s[7:0], m[0]);
      @(posedge clk);
      #1 check("random", res, model(o, e, d, s, m));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
